// File: rtl/mux_pkg.sv
// mux_pkg: state and mode encodings shared by the mux_scan channel selector
package mux_pkg;
   typedef enum logic [1:0] {IDLE, MANUAL, SCAN} mux_state_e;
   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN = 1'b1;
endpackage

// File: rtl/mux_sel_core.sv
// mux_sel_core: combinational N_CH:1 selector of DW-bit channel slices
module mux_sel_core #(
   parameter int N_CH = 16,
   parameter int DW = 1,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic [N_CH*DW-1:0] data_i,
   input  logic [SEL_W-1:0]   sel_i,
   output logic [DW-1:0]      data_o
);
   always_comb begin
      data_o = '0;
      for (int c = 0; c < N_CH; c++)
         if (sel_i == SEL_W'(c)) data_o = data_i[c*DW +: DW];
   end
endmodule

// File: rtl/mux_scan.sv
// mux_scan: registered N_CH:1 channel selector with valid/ready output and round-robin scan
module mux_scan
   import mux_pkg::*;
#(
   parameter int N_CH = 16,
   parameter int DW = 1,
   parameter int SEL_W = $clog2(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              mode,
   input  logic [N_CH*DW-1:0] in_data,
   input  logic [SEL_W-1:0]  sel_in,
   input  logic              sel_load,
   input  logic [7:0]        dwell,
   output logic [DW-1:0]     out_data,
   output logic [SEL_W-1:0]  out_ch,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              sel_err,
   output logic              wrap
);
   mux_state_e st_q, st_d;
   logic [SEL_W-1:0] ptr_q, ptr_d, ch_q, ch_d;
   logic [7:0] cnt_q, cnt_d;
   logic [DW-1:0] data_q, data_d, sel_data;
   logic valid_q, valid_d, err_q, err_d, wrap_q, wrap_d;
   logic load_ok, cap, acc, mode_chg, step, adv, last;

   mux_sel_core #(.N_CH(N_CH), .DW(DW), .SEL_W(SEL_W)) u_core (
      .data_i(in_data),
      .sel_i (ptr_q),
      .data_o(sel_data)
   );

   // Decisions use this cycle's en/mode so capture starts on the first enabled edge
   always_comb begin
      st_d = !en ? IDLE : (mode == MODE_SCAN ? SCAN : MANUAL);
      load_ok = sel_load && (sel_in <= SEL_W'(N_CH - 1));
      acc = valid_q && out_ready;
      cap = (st_d != IDLE) && (!valid_q || out_ready);
      mode_chg = (st_q != IDLE) && (st_d != IDLE) && (st_q != st_d);
      step = (st_d == SCAN) && acc && !load_ok && !mode_chg;
      adv = step && (cnt_q == dwell);
      last = ptr_q == SEL_W'(N_CH - 1);
      ptr_d = load_ok ? sel_in : adv ? (last ? '0 : ptr_q + 1'b1) : ptr_q;
      cnt_d = (load_ok || mode_chg || adv) ? 8'd0 : step ? cnt_q + 8'd1 : cnt_q;
      data_d = cap ? sel_data : data_q;
      ch_d = cap ? ptr_q : ch_q;
      valid_d = cap || (valid_q && !out_ready);
      err_d = sel_load && !load_ok;
      wrap_d = adv && last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q <= IDLE;
         ptr_q <= '0;
         cnt_q <= '0;
         data_q <= '0;
         ch_q <= '0;
         valid_q <= 1'b0;
         err_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         st_q <= st_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         data_q <= data_d;
         ch_q <= ch_d;
         valid_q <= valid_d;
         err_q <= err_d;
         wrap_q <= wrap_d;
      end
   end

   assign out_data = data_q;
   assign out_ch = ch_q;
   assign out_valid = valid_q;
   assign sel_err = err_q;
   assign wrap = wrap_q;
endmodule

// File: tb/tb_mux_scan.sv
// tb_mux_scan: randomized scoreboard bench for mux_scan with 12 channels of 8 bits
module tb_mux_scan;
   localparam int N = 12, DW = 8, SW = 4;
   logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0, sel_load = 1'b0, out_ready = 1'b0;
   logic [N*DW-1:0] in_data = '0;
   logic [SW-1:0] sel_in = '0;
   logic [7:0] dwell = '0;
   logic [DW-1:0] out_data;
   logic [SW-1:0] out_ch;
   logic out_valid, sel_err, wrap;
   int tests = 0, fails = 0;

   typedef struct {logic [DW-1:0] d; int ch;} item_t;
   item_t q[$];
   int m_ptr, m_cnt, m_state;
   bit m_valid, m_err, m_wrap;

   always #5 clk = ~clk;

   mux_scan #(.N_CH(N), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_data(in_data),
      .sel_in(sel_in), .sel_load(sel_load), .dwell(dwell), .out_data(out_data),
      .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
      .sel_err(sel_err), .wrap(wrap)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic mreset();
      m_ptr = 0; m_cnt = 0; m_state = 0;
      m_valid = 0; m_err = 0; m_wrap = 0;
      q.delete();
   endtask

   // Reference: m_state 0 idle, 1 manual, 2 scan; advanced once per rising edge
   task automatic step();
      int ns;
      bit acc, ld;
      if (!rst_n) begin
         mreset();
         return;
      end
      ns = !en ? 0 : (mode ? 2 : 1);
      acc = m_valid && out_ready;
      ld = sel_load && (int'(sel_in) < N);
      m_err = sel_load && !ld;
      m_wrap = 0;
      if (ns != 0 && (!m_valid || out_ready)) begin
         q.push_back('{in_data[m_ptr*DW +: DW], m_ptr});
         m_valid = 1;
      end else if (acc) m_valid = 0;
      if (ld) begin
         m_ptr = int'(sel_in);
         m_cnt = 0;
      end else if (m_state != 0 && ns != 0 && m_state != ns) m_cnt = 0;
      else if (ns == 2 && acc) begin
         if (m_cnt == int'(dwell)) begin
            m_cnt = 0;
            m_ptr = (m_ptr + 1) % N;
            m_wrap = (m_ptr == 0);
         end else m_cnt++;
      end
      m_state = ns;
   endtask

   task automatic cyc();
      @(posedge clk);
      step();
      #1;
   endtask

   always @(negedge clk) begin
      item_t e;
      chk("out_valid", out_valid, m_valid);
      chk("sel_err", sel_err, m_err);
      chk("wrap", wrap, m_wrap);
      if (out_valid && out_ready) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: DUT presented ch %0d data %0d with nothing expected", out_ch, out_data);
         end else begin
            e = q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_ch", out_ch, e.ch);
         end
      end
   end

   initial begin
      mreset();
      for (int c = 0; c < N; c++) in_data[c*DW +: DW] = 8'(c + 16);
      repeat (2) cyc();
      en = 1; mode = 0; out_ready = 1; rst_n = 1;
      cyc();
      chk("first_valid", out_valid, 1);
      chk("first_ch", out_ch, 0);
      chk("first_data", out_data, 8'h10);
      repeat (3) cyc();
      #2 rst_n = 0;
      mreset();
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ch", out_ch, 0);
      chk("rst_err", sel_err, 0);
      chk("rst_wrap", wrap, 0);
      cyc();
      rst_n = 1;
      cyc();
      chk("rerun_ch", out_ch, 0);
      sel_in = 5; sel_load = 1; cyc();
      sel_load = 0; cyc();
      chk("man5_data", out_data, 8'h15);
      chk("man5_ch", out_ch, 5);
      sel_in = 11; sel_load = 1; cyc();
      sel_load = 0; cyc();
      chk("man11_data", out_data, 8'h1B);
      sel_in = 13; sel_load = 1; cyc();
      chk("err13_pulse", sel_err, 1);
      sel_load = 0; cyc();
      chk("err13_clear", sel_err, 0);
      chk("err13_ch", out_ch, 11);
      sel_in = 0; sel_load = 1; cyc();
      sel_load = 0; dwell = 2; mode = 1;
      repeat (45) cyc();
      out_ready = 0;
      repeat (5) begin
         in_data = {$urandom, $urandom, $urandom};
         cyc();
      end
      out_ready = 1;
      dwell = 0;
      for (int i = 0; i < 40 && m_ptr != N - 1; i++) cyc();
      sel_in = 2; sel_load = 1; cyc();
      sel_load = 0;
      chk("simul_wrap", wrap, 0);
      cyc();
      chk("simul_ch", out_ch, 2);
      for (int i = 0; i < 800; i++) begin
         en = $urandom_range(0, 9) != 0;
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         sel_load = $urandom_range(0, 11) == 0;
         sel_in = SW'($urandom_range(0, 15));
         if ($urandom_range(0, 30) == 0) dwell = 8'($urandom_range(0, 3));
         out_ready = $urandom_range(0, 3) != 0;
         in_data = {$urandom, $urandom, $urandom};
         cyc();
      end
      en = 0; sel_load = 0; out_ready = 1;
      repeat (3) cyc();
      chk("drain_valid", out_valid, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/mux_scan.md
# mux_scan

Registered, parametrised N:1 channel selector with a valid/ready output stage and an auto-scan mode. It generalises the fixed 16:1 single-bit selector to N_CH channels of DW bits each. Channel selection can be loaded and validated explicitly (manual mode) or stepped round-robin with a programmable dwell (scan mode). It sits between a bank of parallel sample sources and a single streaming consumer.

## Interface
- `N_CH`, default 16: number of input channels, 2..256.
- `DW`, default 1: bits per channel.
- `SEL_W`, default $clog2(N_CH): channel index width.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `en` input 1: block enable.
- `mode` input 1: 0 = manual, 1 = scan.
- `in_data` input N_CH*DW: channel c occupies bits [c*DW +: DW].
- `sel_in` input SEL_W: requested channel.
- `sel_load` input 1: load `sel_in` this cycle.
- `dwell` input 8: accepted samples per channel in scan mode, minus one.
- `out_data` output DW: registered selected sample.
- `out_ch` output SEL_W: channel index of `out_data`.
- `out_valid` output 1: output holds a sample.
- `out_ready` input 1: consumer accepts the sample.
- `sel_err` output 1: one-cycle pulse when a load is rejected.
- `wrap` output 1: one-cycle pulse when the scan pointer wraps to 0.

## Operation
- State machine:
  - IDLE (`en`=0).
  - MANUAL (`en`=1, `mode`=0).
  - SCAN (`en`=1, `mode`=1).
  - The state follows `en`/`mode` every cycle.
- Pointer `ptr` (SEL_W bits) selects the channel. Dwell counter `cnt` is 8 bits.
- Load, in any state:
  - `sel_load` with `sel_in` < N_CH: `ptr` <= `sel_in`, `cnt` <= 0.
  - `sel_load` with `sel_in` >= N_CH: `ptr` is unchanged and `sel_err` pulses.
  - A load overrides the scan advance in the same cycle.
- Capture condition (MANUAL or SCAN): the slot is free, i.e. `!out_valid || out_ready`. On capture:
  - `out_data` <= in_data[ptr*DW +: DW].
  - `out_ch` <= `ptr`.
  - `out_valid` <= 1.
- Capture uses `ptr` as it stands before any same-cycle load or advance.
- Scan advance: only in SCAN, on an accepted transfer (`out_valid && out_ready`).
  - If `cnt` == `dwell`: `cnt` <= 0 and `ptr` <= (`ptr` == N_CH-1) ? 0 : `ptr`+1. On the wrap to 0, `wrap` pulses.
  - Otherwise `cnt` <= `cnt`+1.
- MANUAL never advances `ptr`. `cnt` holds.
- Mode change MANUAL<->SCAN: `cnt` <= 0 and `ptr` is retained, so the scan starts at the current channel.
- IDLE:
  - No capture.
  - A pending `out_valid` stays asserted until accepted, then clears.
  - `ptr` and `cnt` hold.
- Handshake rule: while `out_valid`=1 and `out_ready`=0, `out_data` and `out_ch` are stable.

## Timing
- Reset values: `out_data`=0, `out_ch`=0, `out_valid`=0, `sel_err`=0, `wrap`=0, `ptr`=0, `cnt`=0, state IDLE.
- Latency: `in_data` is sampled at the capture edge. `out_valid` rises on that edge, 1 cycle after `en` goes high.
- Throughput: 1 sample/cycle when `out_ready` is held high.
- Load at edge k takes effect for the capture at edge k+1.
- `sel_err` and `wrap` are registered, high for exactly one cycle.
- Reset asserted mid-transfer: all outputs go to reset values immediately. There is no residual valid.
- N_CH not a power of two: `ptr` never exceeds N_CH-1; out-of-range indices are unreachable.

## Structure
- Shared package `mux_pkg`:
  - State enum `mux_state_e` {IDLE, MANUAL, SCAN}.
  - Mode constants `MODE_MANUAL`=0 and `MODE_SCAN`=1.
- Single sub-module `mux_sel_core`: a purely combinational N_CH:1 DW-wide indexed part-select. All registers and the FSM stay in `mux_scan`.

## Test plan
- Reset, N_CH=16, DW=1:
  - Assert `rst_n`=0 mid-stream: all outputs are 0 asynchronously.
  - Release with `en`=1, `mode`=0: first `out_valid` one cycle later, `out_ch`=0.
- Manual select, N_CH=16, DW=8, `in_data` channel c = c+8'h10, `out_ready`=1:
  - Load `sel_in`=5: next capture gives `out_data`=8'h15, `out_ch`=5.
  - Load `sel_in`=15: gives 8'h1F.
- Rejected load, N_CH=12: `sel_load` with `sel_in`=13 -> `sel_err` pulses 1 cycle; `out_ch` stays at the prior value.
- Scan with dwell, N_CH=4, `dwell`=2, `out_ready`=1: `out_ch` sequence 0,0,0,1,1,1,2,2,2,3,3,3,0, with `wrap` pulsing once on the return to 0.
- Backpressure: hold `out_ready`=0 for 5 cycles while `in_data` changes -> `out_data` and `out_ch` stay constant. In scan mode `ptr` does not advance.
- Simultaneous events: in SCAN with `cnt`==`dwell`, assert `sel_load` `sel_in`=2 during an accepted transfer -> `ptr`=2, `cnt`=0, no `wrap`.
